// File: rtl/univ_shift_reg_pkg.sv
// -----------------------------------------------------------------------------
// univ_shift_reg_pkg
//   Shared types for the universal shift register.
//   - mode_e        : 3-bit operation select
//   - state_e       : auto-run sequencer states
//   - is_shift_mode : true for the modes an auto-run can repeat (SHL..ASR)
// -----------------------------------------------------------------------------
package univ_shift_reg_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'd0,
    MODE_LOAD = 3'd1,
    MODE_SHL  = 3'd2,
    MODE_SHR  = 3'd3,
    MODE_ROL  = 3'd4,
    MODE_ROR  = 3'd5,
    MODE_ASR  = 3'd6,
    MODE_RSVD = 3'd7
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic is_shift_mode(input mode_e m);
    return (m inside {MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR});
  endfunction

endpackage

// File: rtl/univ_shift_reg_shift.sv
// -----------------------------------------------------------------------------
// shift_unit
//   Purely combinational next-value logic for the shift register. The same
//   instance serves manual single ops and auto-run steps; the caller picks
//   which mode drives it.
//   Ports:
//     q       in  WIDTH  current register value
//     mode    in  mode_e operation to apply
//     ser_l_i in  1      serial fill at MSB (SHR)
//     ser_r_i in  1      serial fill at LSB (SHL)
//     d_i     in  WIDTH  parallel load data
//     next_q  out WIDTH  value after applying mode to q
// -----------------------------------------------------------------------------
module shift_unit
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  mode_e            mode,
  input  logic             ser_l_i,
  input  logic             ser_r_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] next_q
);

  always_comb begin
    next_q = q;
    case (mode)
      MODE_LOAD: next_q = d_i;
      MODE_SHL:  next_q = {q[WIDTH-2:0], ser_r_i};
      MODE_SHR:  next_q = {ser_l_i, q[WIDTH-1:1]};
      MODE_ROL:  next_q = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROR:  next_q = {q[0], q[WIDTH-1:1]};
      MODE_ASR:  next_q = {q[WIDTH-1], q[WIDTH-1:1]};
      default:   next_q = q;   // HOLD and the reserved code both hold
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// -----------------------------------------------------------------------------
// univ_shift_reg
//   WIDTH-bit universal shift register with complementary outputs. Performs
//   one op per enabled cycle (manual) or an auto-sequenced run of cnt_i
//   shifts with a busy/done handshake.
//   Ports:
//     clk_i    in  1      clock, rising edge
//     rst_n_i  in  1      asynchronous reset, active low
//     clr_i    in  1      synchronous clear (aborts a run, no done)
//     en_i     in  1      enable for manual ops and run progress
//     mode_i   in  3      operation select (see mode_e)
//     d_i      in  WIDTH  parallel load data
//     ser_l_i  in  1      serial in at MSB
//     ser_r_i  in  1      serial in at LSB
//     start_i  in  1      start an auto-run of cnt_i shifts
//     cnt_i    in  CNT_W  auto-run shift count
//     q_o      out WIDTH  register value
//     qb_o     out WIDTH  ~q_o
//     ser_l_o  out 1      q_o MSB
//     ser_r_o  out 1      q_o LSB
//     busy_o   out 1      auto-run in progress
//     done_o   out 1      single-cycle pulse when a run completes
// -----------------------------------------------------------------------------
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [2:0]       mode_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             ser_l_i,
  input  logic             ser_r_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] qb_o,
  output logic             ser_l_o,
  output logic             ser_r_o,
  output logic             busy_o,
  output logic             done_o
);

  state_e           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg,   cnt_next;
  mode_e            mode_reg,  mode_next;
  logic [WIDTH-1:0] q_reg,     q_next;
  logic             done_reg,  done_next;

  mode_e            mode_in;
  mode_e            op_mode;
  logic [WIDTH-1:0] shift_q;

  assign mode_in = mode_e'(mode_i);

  // While running, the latched mode drives the datapath so mode_i changes
  // mid-run have no effect.
  assign op_mode = (state_reg == ST_RUN) ? mode_reg : mode_in;

  shift_unit #(
    .WIDTH (WIDTH)
  ) u_shift (
    .q       (q_reg),
    .mode    (op_mode),
    .ser_l_i (ser_l_i),
    .ser_r_i (ser_r_i),
    .d_i     (d_i),
    .next_q  (shift_q)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      mode_reg  <= MODE_HOLD;
      q_reg     <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      mode_reg  <= mode_next;
      q_reg     <= q_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    mode_next  = mode_reg;
    q_next     = q_reg;
    done_next  = 1'b0;   // done is a pulse unless set below

    if (clr_i) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
      q_next     = '0;
    end else if (state_reg == ST_RUN) begin
      if (en_i) begin
        q_next   = shift_q;
        cnt_next = cnt_reg - CNT_W'(1);
        // Last shift and done pulse share the same edge.
        if (cnt_reg == CNT_W'(1)) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
    end else if (start_i && en_i && is_shift_mode(mode_in)) begin
      if (cnt_i != '0) begin
        // Capture edge only: the first shift happens on the next edge.
        state_next = ST_RUN;
        cnt_next   = cnt_i;
        mode_next  = mode_in;
      end else begin
        done_next  = 1'b1;   // empty run completes immediately
      end
    end else if (en_i) begin
      q_next = shift_q;
    end
  end

  assign q_o     = q_reg;
  assign qb_o    = ~q_reg;
  assign ser_l_o = q_reg[WIDTH-1];
  assign ser_r_o = q_reg[0];
  assign busy_o  = (state_reg == ST_RUN);
  assign done_o  = done_reg;

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;

  localparam int W    = 8;
  localparam int CW   = 4;
  localparam int MOD  = 1 << W;
  localparam int HALF = MOD / 2;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          clr_i;
  logic          en_i;
  logic [2:0]    mode_i;
  logic [W-1:0]  d_i;
  logic          ser_l_i;
  logic          ser_r_i;
  logic          start_i;
  logic [CW-1:0] cnt_i;
  logic [W-1:0]  q_o;
  logic [W-1:0]  qb_o;
  logic          ser_l_o;
  logic          ser_r_o;
  logic          busy_o;
  logic          done_o;

  int checks = 0;
  int errors = 0;

  // Reference model state (plain integers)
  int m_q;
  int m_left;
  int m_mode;
  int m_busy;
  int m_done;

  univ_shift_reg #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (clr_i),
    .en_i    (en_i),
    .mode_i  (mode_i),
    .d_i     (d_i),
    .ser_l_i (ser_l_i),
    .ser_r_i (ser_r_i),
    .start_i (start_i),
    .cnt_i   (cnt_i),
    .q_o     (q_o),
    .qb_o    (qb_o),
    .ser_l_o (ser_l_o),
    .ser_r_o (ser_r_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  always #5 clk_i = ~clk_i;

  // Operation semantics as arithmetic on an unsigned integer value.
  function automatic int apply(input int m, input int q, input int d,
                               input int sl, input int sr);
    case (m)
      1:       return d;
      2:       return (q * 2) % MOD + sr;
      3:       return q / 2 + sl * HALF;
      4:       return (q * 2) % MOD + q / HALF;
      5:       return q / 2 + (q % 2) * HALF;
      6:       return q / 2 + (q / HALF) * HALF;
      default: return q;
    endcase
  endfunction

  function automatic int is_shift(input int m);
    return (m >= 2 && m <= 6) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_q = 0; m_left = 0; m_mode = 0; m_busy = 0; m_done = 0;
  endtask

  task automatic model_edge();
    int nd;
    nd = 0;
    if (!rst_n_i) begin
      model_reset();
      return;
    end
    if (clr_i) begin
      m_q = 0; m_busy = 0; m_left = 0;
    end else if (m_busy != 0) begin
      if (en_i) begin
        m_q    = apply(m_mode, m_q, int'(d_i), int'(ser_l_i), int'(ser_r_i));
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_busy = 0; nd = 1;
        end
      end
    end else if (start_i && en_i && is_shift(int'(mode_i)) != 0) begin
      if (cnt_i != 0) begin
        m_busy = 1; m_left = int'(cnt_i); m_mode = int'(mode_i);
      end else begin
        nd = 1;
      end
    end else if (en_i) begin
      m_q = apply(int'(mode_i), m_q, int'(d_i), int'(ser_l_i), int'(ser_r_i));
    end
    m_done = nd;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("q",     32'(q_o),     32'(m_q));
    chk("qb",    32'(qb_o),    32'((~m_q) & (MOD - 1)));
    chk("busy",  32'(busy_o),  32'(m_busy));
    chk("done",  32'(done_o),  32'(m_done));
    chk("ser_l", 32'(ser_l_o), 32'(m_q / HALF));
    chk("ser_r", 32'(ser_r_o), 32'(m_q % 2));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk_i);
    #1;
    chk_all();
  endtask

  task automatic op(input logic [2:0] m, input logic [W-1:0] d,
                    input logic st, input logic [CW-1:0] c);
    mode_i = m; d_i = d; start_i = st; cnt_i = c;
    tick();
  endtask

  int busy_cnt;
  int done_cnt;

  initial begin
    rst_n_i = 1'b0; clr_i = 1'b0; en_i = 1'b0; mode_i = 3'd0; d_i = '0;
    ser_l_i = 1'b0; ser_r_i = 1'b0; start_i = 1'b0; cnt_i = '0;
    model_reset();
    #2;
    chk_all();
    chk("reset_qb", 32'(qb_o), 32'hFF);
    #6;
    rst_n_i = 1'b1;
    en_i    = 1'b1;

    // Manual ops
    op(3'd1, 8'h81, 1'b0, 4'd0); chk("ld81", 32'(q_o), 32'h81);
    ser_r_i = 1'b1;
    op(3'd2, 8'h00, 1'b0, 4'd0); chk("shl", 32'(q_o), 32'h03);
    ser_r_i = 1'b0; ser_l_i = 1'b0;
    op(3'd3, 8'h00, 1'b0, 4'd0); chk("shr", 32'(q_o), 32'h01);
    op(3'd1, 8'h80, 1'b0, 4'd0);
    op(3'd6, 8'h00, 1'b0, 4'd0); chk("asr", 32'(q_o), 32'hC0);
    op(3'd1, 8'h01, 1'b0, 4'd0);
    op(3'd5, 8'h00, 1'b0, 4'd0); chk("ror", 32'(q_o), 32'h80);
    en_i = 1'b0;
    op(3'd1, 8'h33, 1'b0, 4'd0); chk("en_hold", 32'(q_o), 32'h80);
    en_i = 1'b1;
    op(3'd7, 8'h33, 1'b0, 4'd0); chk("rsvd_hold", 32'(q_o), 32'h80);

    // Auto run: ROR x3 on 0x96
    op(3'd1, 8'h96, 1'b0, 4'd0);
    op(3'd5, 8'h00, 1'b1, 4'd3); chk("run_cap", 32'(q_o), 32'h96);
    op(3'd0, 8'h00, 1'b0, 4'd0); chk("run1", 32'(q_o), 32'h4B);
    op(3'd0, 8'h00, 1'b0, 4'd0); chk("run2", 32'(q_o), 32'hA5);
    op(3'd0, 8'h00, 1'b0, 4'd0); chk("run3", 32'(q_o), 32'hD2);
    chk("run3_done", 32'(done_o), 32'd1);
    op(3'd0, 8'h00, 1'b0, 4'd0); chk("run_done_clr", 32'(done_o), 32'd0);

    // Stall: SHL x4 on 0xFF, en low 2 cycles mid-run
    op(3'd1, 8'hFF, 1'b0, 4'd0);
    ser_r_i = 1'b0; busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      en_i = (i == 3 || i == 4) ? 1'b0 : 1'b1;
      op((i == 0) ? 3'd2 : 3'd0, 8'h00, (i == 0) ? 1'b1 : 1'b0, 4'd4);
      if (busy_o) busy_cnt++;
      if (done_o) done_cnt++;
    end
    en_i = 1'b1;
    chk("stall_busy", 32'(busy_cnt), 32'd6);
    chk("stall_done", 32'(done_cnt), 32'd1);
    chk("stall_q", 32'(q_o), 32'hF0);

    // Zero count: immediate done, no busy
    op(3'd3, 8'h00, 1'b1, 4'd0);
    chk("zc_done", 32'(done_o), 32'd1);
    chk("zc_busy", 32'(busy_o), 32'd0);
    chk("zc_q", 32'(q_o), 32'hF0);
    op(3'd0, 8'h00, 1'b0, 4'd0);

    // Clear during run
    op(3'd1, 8'h5A, 1'b0, 4'd0);
    op(3'd4, 8'h00, 1'b1, 4'd5);
    op(3'd0, 8'h00, 1'b0, 4'd0);
    clr_i = 1'b1;
    op(3'd0, 8'h00, 1'b0, 4'd0);
    chk("clr_q", 32'(q_o), 32'h00);
    chk("clr_busy", 32'(busy_o), 32'd0);
    clr_i = 1'b0;
    op(3'd0, 8'h00, 1'b0, 4'd0);
    op(3'd0, 8'h00, 1'b0, 4'd0);

    // Inputs ignored during run
    op(3'd1, 8'h01, 1'b0, 4'd0);
    op(3'd4, 8'h00, 1'b1, 4'd2);
    op(3'd1, 8'hFF, 1'b0, 4'd0);
    op(3'd1, 8'hFF, 1'b1, 4'd0);
    chk("ign_q", 32'(q_o), 32'h04);
    op(3'd0, 8'h00, 1'b0, 4'd0);

    // Async reset mid-run
    op(3'd1, 8'hA5, 1'b0, 4'd0);
    op(3'd4, 8'h00, 1'b1, 4'd5);
    op(3'd0, 8'h00, 1'b0, 4'd0);
    op(3'd0, 8'h00, 1'b0, 4'd0);
    #2;
    rst_n_i = 1'b0;
    model_reset();
    #1;
    chk_all();
    chk("arst_qb", 32'(qb_o), 32'hFF);
    #2;
    rst_n_i = 1'b1;
    op(3'd0, 8'h00, 1'b0, 4'd0);
    op(3'd0, 8'h00, 1'b0, 4'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      en_i    = ($urandom_range(0, 9) != 0);
      clr_i   = ($urandom_range(0, 39) == 0);
      ser_l_i = 1'($urandom);
      ser_r_i = 1'($urandom);
      op(3'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0),
         4'($urandom_range(0, 15)));
    end
    clr_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
